// File: rtl/conv1_line_buf_if.sv
// Pixel-stream in / 3x3 window out bundle for conv1_line_buf.
// frame_done exists only when CONV1_LINE_BUF_FRAME_DONE_EN is defined.
interface conv1_line_buf_if;
  logic valid_in;
  logic sof;
  logic pixel_in;
  logic pixel_0, pixel_1, pixel_2;
  logic pixel_3, pixel_4, pixel_5;
  logic pixel_6, pixel_7, pixel_8;
  logic valid_out_buf;
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
  logic frame_done;

  modport master (
    output valid_in, sof, pixel_in,
    input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf, frame_done
  );
  modport slave (
    input  valid_in, sof, pixel_in,
    output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf, frame_done
  );
`else
  modport master (
    output valid_in, sof, pixel_in,
    input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf
  );
  modport slave (
    input  valid_in, sof, pixel_in,
    output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf
  );
`endif
endinterface

// File: rtl/conv1_line_buf.sv
// 3x3 binary window generator: two shift-register line buffers feed a 3x3 window.
// Optional frame_done pulse under macro CONV1_LINE_BUF_FRAME_DONE_EN.
module conv1_line_buf #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input logic             clk,
  input logic             rst,
  conv1_line_buf_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [IMG_W-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
  // win_q[row][col]: row 0 is the oldest line, col 0 the oldest column
  logic [2:0][2:0]  win_q, win_d;
  logic [2:0]       new_col;
  logic [8:0]       pix_q, pix_d;
  logic             vld_q, vld_d;
  logic             beat, win_ok;
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
  logic             fd_q, fd_d;
`endif

  always_comb begin
    beat    = bus.valid_in;
    // sof pins the current beat to (0,0) regardless of the counters
    cur_col = bus.sof ? '0 : col_q;
    cur_row = bus.sof ? '0 : row_q;
    win_ok  = beat && (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);
    new_col = {bus.pixel_in, lb1_q[IMG_W-1], lb2_q[IMG_W-1]};

    col_d = col_q;
    row_d = row_q;
    lb1_d = lb1_q;
    lb2_d = lb2_q;
    win_d = win_q;
    if (beat) begin
      lb1_d = {lb1_q[IMG_W-2:0], bus.pixel_in};
      lb2_d = {lb2_q[IMG_W-2:0], lb1_q[IMG_W-1]};
      for (int i = 0; i < 3; i++)
        win_d[i] = {new_col[i], win_q[i][2:1]};
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Output regs load only on a complete window so pixel_* hold otherwise
  always_comb begin
    vld_d = win_ok;
    pix_d = pix_q;
    if (win_ok)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          pix_d[3*i+j] = win_d[i][j];
  end

`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
  always_comb fd_d = beat && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      lb1_q <= '0;
      lb2_q <= '0;
      win_q <= '0;
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lb1_q <= lb1_d;
      lb2_q <= lb2_d;
      win_q <= win_d;
      pix_q <= pix_d;
      vld_q <= vld_d;
    end
  end

`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fd_q <= 1'b0;
    else     fd_q <= fd_d;
  end
  assign bus.frame_done = fd_q;
`endif

  assign bus.valid_out_buf = vld_q;
  assign bus.pixel_0 = pix_q[0];
  assign bus.pixel_1 = pix_q[1];
  assign bus.pixel_2 = pix_q[2];
  assign bus.pixel_3 = pix_q[3];
  assign bus.pixel_4 = pix_q[4];
  assign bus.pixel_5 = pix_q[5];
  assign bus.pixel_6 = pix_q[6];
  assign bus.pixel_7 = pix_q[7];
  assign bus.pixel_8 = pix_q[8];
endmodule

// File: tb/tb_conv1_line_buf.sv
// Bench for conv1_line_buf: image-array reference model checked every cycle,
// table of whole-frame scenarios, plus reset/sof/back-to-back sequences.
module tb_conv1_line_buf;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk, rst;
  conv1_line_buf_if bus();

  conv1_line_buf #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         img [0:H-1][0:W-1];
  int         mp;
  logic [8:0] exp_pix;
  logic       exp_vld, exp_fd;

  // observed statistics
  int         n_strobe, n_beat, first_idx, n_fd, fd_bad;
  logic [8:0] win0, win1;

  typedef struct {
    int         pat;     // 0 ones, 1 checkerboard
    bit         gaps;
    int         exp_cnt;
    int         exp_first;
    logic [8:0] exp_w0;
    logic [8:0] exp_w1;
  } vec_t;
  vec_t vecs [3];

  function automatic logic [8:0] dut_pix();
    return {bus.pixel_8, bus.pixel_7, bus.pixel_6, bus.pixel_5, bus.pixel_4,
            bus.pixel_3, bus.pixel_2, bus.pixel_1, bus.pixel_0};
  endfunction

  function automatic logic dut_fd();
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
    return bus.frame_done;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mp = 0; exp_pix = '0; exp_vld = 1'b0; exp_fd = 1'b0;
  endtask

  task automatic clear_stats();
    n_strobe = 0; n_beat = 0; first_idx = -1; n_fd = 0; fd_bad = 0;
    win0 = '0; win1 = '0;
  endtask

  // one clock: drive, update model for the accepted beat, compare 1 ns after edge
  task automatic step(input logic v, input logic s, input logic px);
    int r, c;
    logic [10:0] got, exp;
    @(negedge clk);
    bus.valid_in = v; bus.sof = s; bus.pixel_in = px;
    @(posedge clk);
    exp_vld = 1'b0; exp_fd = 1'b0;
    if (v) begin
      if (s) mp = 0;
      r = mp / W; c = mp % W;
      img[r][c] = px;
      if (r >= 2 && c >= 2) begin
        exp_vld = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_pix[3*i+j] = img[r-2+i][c-2+j];
      end
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
      exp_fd = (r == H - 1) && (c == W - 1);
`endif
      mp = (mp + 1) % NPIX;
      n_beat++;
    end
    #1;
    got = {dut_fd(), bus.valid_out_buf, dut_pix()};
    exp = {exp_fd, exp_vld, exp_pix};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle t=%0t: got fd/vld/pix=%b expected %b", $time, got, exp);
    end
    if (bus.valid_out_buf === 1'b1) begin
      if (n_strobe == 0) begin win0 = dut_pix(); first_idx = n_beat - 1; end
      if (n_strobe == 1) win1 = dut_pix();
      n_strobe++;
    end
    if (dut_fd() === 1'b1) begin
      n_fd++;
      if (n_strobe % NWIN != 0) fd_bad++;
    end
  endtask

  task automatic run_pixels(input int pat, input bit gaps, input bit first_sof, input int n);
    int r, c;
    logic px;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / W; c = idx % W;
      px = (pat == 0) ? 1'b1 : (pat == 1) ? 1'((r + c) % 2) : 1'($urandom % 2);
      step(1'b1, first_sof && idx == 0, px);
      if (gaps) begin
        // sof with valid_in low must be ignored
        step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
        repeat ($urandom_range(0, 5)) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
      end
    end
  endtask

  initial begin
    vecs[0] = '{pat: 0, gaps: 1'b0, exp_cnt: NWIN, exp_first: 58, exp_w0: 9'h1FF, exp_w1: 9'h1FF};
    vecs[1] = '{pat: 1, gaps: 1'b0, exp_cnt: NWIN, exp_first: 58, exp_w0: 9'h0AA, exp_w1: 9'h155};
    vecs[2] = '{pat: 1, gaps: 1'b1, exp_cnt: NWIN, exp_first: 58, exp_w0: 9'h0AA, exp_w1: 9'h155};

    rst = 1'b1;
    bus.valid_in = 1'b0; bus.sof = 1'b0; bus.pixel_in = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({dut_fd(), bus.valid_out_buf, dut_pix()}), 0);
    rst = 1'b0;

    // whole-frame scenario table
    for (int k = 0; k < 3; k++) begin
      clear_stats();
      run_pixels(vecs[k].pat, vecs[k].gaps, 1'b1, NPIX);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_count", k), n_strobe, vecs[k].exp_cnt);
      chk($sformatf("v%0d_first", k), first_idx, vecs[k].exp_first);
      chk($sformatf("v%0d_win0", k), int'(win0), int'(vecs[k].exp_w0));
      chk($sformatf("v%0d_win1", k), int'(win1), int'(vecs[k].exp_w1));
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
      chk($sformatf("v%0d_fd", k), n_fd, 1);
`endif
    end

    // asynchronous reset mid-cycle after 100 pixels
    clear_stats();
    run_pixels(0, 1'b0, 1'b1, 100);
    #1 rst = 1'b1;
    bus.valid_in = 1'b0;
    #1 chk("async_reset_outputs", int'({dut_fd(), bus.valid_out_buf, dut_pix()}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    run_pixels(1, 1'b0, 1'b0, NPIX);
    step(1'b0, 1'b0, 1'b0);
    chk("post_reset_count", n_strobe, NWIN);
    chk("post_reset_first", first_idx, 58);

    // sof restart on pixel 300
    clear_stats();
    run_pixels(1, 1'b0, 1'b1, 300);
    chk("pre_sof_fd", n_fd, 0);
    clear_stats();
    run_pixels(1, 1'b0, 1'b1, NPIX);
    step(1'b0, 1'b0, 1'b0);
    chk("sof_first", first_idx, 58);
    chk("sof_count", n_strobe, NWIN);
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
    chk("sof_fd", n_fd, 1);
`endif

    // two back-to-back frames, sof only on the first
    clear_stats();
    run_pixels(0, 1'b0, 1'b1, NPIX);
    run_pixels(1, 1'b0, 1'b0, NPIX);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_count", n_strobe, 2 * NWIN);
`ifdef CONV1_LINE_BUF_FRAME_DONE_EN
    chk("b2b_fd", n_fd, 2);
    chk("b2b_fd_align", fd_bad, 0);
`endif

    // random pixels, random valid, occasional mid-frame sof
    clear_stats();
    for (int i = 0; i < 4000; i++)
      step(1'($urandom % 10 < 7), 1'(i == 0 || $urandom % 600 == 0), 1'($urandom % 2));
    chk("random_nonzero", int'(n_strobe > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
